dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, data-memory word-address width.
REQ-002 Parameter DATA_W, default 16, data-memory word width.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive locked debug grants; legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cpuReq, cpuWrite  in  1 each  CPU datapath access request; write (1) or read (0).
REQ-007 cpuAdrx  in  ADDR_W; cpuWrData  in  DATA_W  CPU access address and write data.
REQ-008 cpuGrant  out  1  CPU access is issued to memory this cycle.
REQ-009 cpuStall  out  1  CPU must hold its request and instruction register.
REQ-010 cpuRdData  out  DATA_W; cpuValid  out  1  CPU read result and its qualifier.
REQ-011 dbgReq, dbgWrite, dbgLock  in  1 each  debug/loader request, write, burst lock.
REQ-012 dbgAdrx  in  ADDR_W; dbgWrData  in  DATA_W  debug access address and write data.
REQ-013 dbgGrant  out  1; dbgRdData  out  DATA_W; dbgValid  out  1  debug grant, read data, qualifier.
REQ-014 memEn, memWrite  out  1 each; memAdrx  out  ADDR_W; memWrData  out  DATA_W  SRAM port.
REQ-015 memRdData  in  DATA_W  SRAM read data, valid one cycle after memEn with memWrite=0.

Function
REQ-016 Grants SHALL be combinational from requests and registered state; at most one grant per cycle.
REQ-017 Only one requester active: it SHALL be granted in the same cycle, except REQ-021.
REQ-018 Both requesting, no active lock: grant SHALL go to the requester not granted most recently (lastOwner register).
REQ-019 On any grant, memEn=1 and memAdrx/memWrite/memWrData SHALL be the granted requester's inputs unmodified; with no grant memEn=0, memWrite=0.
REQ-020 Lock: debug granted with dbgLock=1 SHALL increment burstCnt; while burstCnt in 1..MAX_BURST-1 and dbgReq=1, debug SHALL be granted even if cpuReq=1.
REQ-021 When burstCnt reaches MAX_BURST, the next cycle SHALL grant CPU if cpuReq=1 and SHALL clear burstCnt; if cpuReq=0, burstCnt SHALL clear and debug may be granted again.
REQ-022 burstCnt SHALL clear on any CPU grant, on any cycle with dbgReq=0, and on a debug grant with dbgLock=0.
REQ-023 cpuStall SHALL equal cpuReq AND NOT cpuGrant.
REQ-024 Read granted in cycle N: xxxValid SHALL be 1 in cycle N+1 only, with xxxRdData = memRdData.
REQ-025 Write grants SHALL NOT assert any valid; back-to-back grants SHALL be accepted every cycle (fully pipelined, throughput 1).
REQ-026 RdData outputs SHALL pass memRdData through; they are meaningful only when the matching valid is 1.
REQ-027 State: lastOwner (1 bit), burstCnt (4 bits), pendRdCpu, pendRdDbg (1 bit each); nothing else.

Reset
REQ-028 While reset=1: all grants, memEn, memWrite, cpuValid, dbgValid SHALL be 0; cpuStall SHALL equal cpuReq.
REQ-029 Reset SHALL set lastOwner=debug (CPU wins first contention), burstCnt=0, pending reads cleared.
REQ-030 A read granted in the cycle reset asserts SHALL NOT produce a valid after reset deasserts.

Verification
REQ-031 Only cpuReq=1, read, adrx=0x05 -> cpuGrant=1, memAdrx=0x05, cpuStall=0; next cycle cpuValid=1, cpuRdData=memRdData.
REQ-032 First cycle after reset both request -> CPU granted, dbgGrant=0; next cycle, both still requesting -> debug granted; alternation continues.
REQ-033 MAX_BURST=4, dbgLock=1, both requesting continuously -> dbg grants 4 cycles with cpuStall=1, then 1 CPU grant, then debug again.
REQ-034 dbgWrite=1, adrx=0x7F, data=0xBEEF -> memWrite=1, memAdrx=0x7F, memWrData=0xBEEF, no dbgValid next cycle.
REQ-035 Read granted, reset pulsed the next edge -> cpuValid and dbgValid stay 0, lastOwner=debug, burstCnt=0.
REQ-036 Random req/lock traffic, 10k cycles -> never two grants, every read yields exactly one valid, CPU never waits more than MAX_BURST+1 cycles.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data SRAM between the CPU datapath and a debug/loader port,
// alternating on contention and letting debug hold the port for bounded locked bursts.
module dmem_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpuReq,
  input  logic              cpuWrite,
  input  logic [ADDR_W-1:0] cpuAdrx,
  input  logic [DATA_W-1:0] cpuWrData,
  output logic              cpuGrant,
  output logic              cpuStall,
  output logic [DATA_W-1:0] cpuRdData,
  output logic              cpuValid,
  input  logic              dbgReq,
  input  logic              dbgWrite,
  input  logic              dbgLock,
  input  logic [ADDR_W-1:0] dbgAdrx,
  input  logic [DATA_W-1:0] dbgWrData,
  output logic              dbgGrant,
  output logic [DATA_W-1:0] dbgRdData,
  output logic              dbgValid,
  output logic              memEn,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAdrx,
  output logic [DATA_W-1:0] memWrData,
  input  logic [DATA_W-1:0] memRdData
);
  localparam logic [3:0] MB = 4'(MAX_BURST);
  logic       last_owner_q, last_owner_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       pend_rd_cpu_q, pend_rd_cpu_d;
  logic       pend_rd_dbg_q, pend_rd_dbg_d;
  logic       locked, expired;
  always_comb begin
    locked        = burst_cnt_q != 4'd0 && burst_cnt_q < MB;
    expired       = burst_cnt_q >= MB;
    // last_owner_q = 1 means debug won last; a finished burst hands contention to the CPU
    dbgGrant      = !reset && dbgReq && (locked || !cpuReq || (!expired && !last_owner_q));
    cpuGrant      = !reset && cpuReq && !dbgGrant;
    cpuStall      = cpuReq && !cpuGrant;
    memEn         = cpuGrant || dbgGrant;
    memWrite      = cpuGrant ? cpuWrite : dbgGrant && dbgWrite;
    memAdrx       = dbgGrant ? dbgAdrx : cpuAdrx;
    memWrData     = dbgGrant ? dbgWrData : cpuWrData;
    cpuValid      = pend_rd_cpu_q;
    dbgValid      = pend_rd_dbg_q;
    cpuRdData     = memRdData;
    dbgRdData     = memRdData;
    last_owner_d  = memEn ? dbgGrant : last_owner_q;
    // a locked grant right after an expired burst starts a fresh burst
    burst_cnt_d   = (dbgGrant && dbgLock) ? (expired ? 4'd1 : burst_cnt_q + 4'd1) : 4'd0;
    pend_rd_cpu_d = cpuGrant && !cpuWrite;
    pend_rd_dbg_d = dbgGrant && !dbgWrite;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_q  <= 1'b1;
      burst_cnt_q   <= 4'd0;
      pend_rd_cpu_q <= 1'b0;
      pend_rd_dbg_q <= 1'b0;
    end else begin
      last_owner_q  <= last_owner_d;
      burst_cnt_q   <= burst_cnt_d;
      pend_rd_cpu_q <= pend_rd_cpu_d;
      pend_rd_dbg_q <= pend_rd_dbg_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus random traffic checked against a rule-level reference model.
module tb_dmem_arbiter;
  localparam int AW = 7, DW = 16, MB = 4;
  logic clk = 1'b0, reset;
  logic cpuReq, cpuWrite, dbgReq, dbgWrite, dbgLock;
  logic [AW-1:0] cpuAdrx, dbgAdrx, memAdrx;
  logic [DW-1:0] cpuWrData, dbgWrData, memWrData, memRdData, cpuRdData, dbgRdData;
  logic cpuGrant, cpuStall, cpuValid, dbgGrant, dbgValid, memEn, memWrite;
  int n_cmp = 0, n_err = 0;
  bit m_last_dbg, m_pc, m_pd, n_last_dbg, n_pc, n_pd, have_next;
  int m_run, n_run, cpu_wait;
  logic [6:0] pat;
  always #5 clk = ~clk;
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .cpuReq(cpuReq), .cpuWrite(cpuWrite), .cpuAdrx(cpuAdrx), .cpuWrData(cpuWrData),
    .cpuGrant(cpuGrant), .cpuStall(cpuStall), .cpuRdData(cpuRdData), .cpuValid(cpuValid),
    .dbgReq(dbgReq), .dbgWrite(dbgWrite), .dbgLock(dbgLock), .dbgAdrx(dbgAdrx), .dbgWrData(dbgWrData),
    .dbgGrant(dbgGrant), .dbgRdData(dbgRdData), .dbgValid(dbgValid),
    .memEn(memEn), .memWrite(memWrite), .memAdrx(memAdrx), .memWrData(memWrData), .memRdData(memRdData)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_check();
    bit ec, ed, live, done;
    if (have_next) begin
      m_last_dbg = n_last_dbg; m_run = n_run; m_pc = n_pc; m_pd = n_pd; have_next = 0;
    end
    if (reset) begin
      m_last_dbg = 1; m_run = 0; m_pc = 0; m_pd = 0; cpu_wait = 0;
    end
    ec = 0; ed = 0;
    live = m_run > 0 && m_run < MB;
    done = m_run >= MB;
    if (!reset) begin
      if (dbgReq && live) ed = 1;
      else if (cpuReq && dbgReq) begin
        if (done || m_last_dbg) ec = 1; else ed = 1;
      end else begin
        ec = cpuReq; ed = dbgReq;
      end
    end
    chk("cpuGrant", cpuGrant, ec);
    chk("dbgGrant", dbgGrant, ed);
    chk("one_grant", cpuGrant & dbgGrant, 0);
    chk("cpuStall", cpuStall, cpuReq & !ec);
    chk("memEn", memEn, ec | ed);
    chk("memWrite", memWrite, (ec & cpuWrite) | (ed & dbgWrite));
    if (ec | ed) begin
      chk("memAdrx", memAdrx, ed ? dbgAdrx : cpuAdrx);
      chk("memWrData", memWrData, ed ? dbgWrData : cpuWrData);
    end
    chk("cpuValid", cpuValid, m_pc);
    chk("dbgValid", dbgValid, m_pd);
    if (m_pc) chk("cpuRdData", cpuRdData, memRdData);
    if (m_pd) chk("dbgRdData", dbgRdData, memRdData);
    if (!reset) begin
      cpu_wait = (cpuReq && !cpuGrant) ? cpu_wait + 1 : 0;
      if (cpu_wait > 0) chk("cpu_wait_bound", cpu_wait <= MB + 1, 1);
    end
    n_last_dbg = (ec | ed) ? ed : m_last_dbg;
    n_run = (ed && dbgLock) ? (done ? 1 : m_run + 1) : 0;
    n_pc = ec && !cpuWrite;
    n_pd = ed && !dbgWrite;
    have_next = 1;
  endtask
  task automatic drive(input logic rs, input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic dr, input logic dw, input logic dl,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd);
    @(negedge clk);
    reset = rs; cpuReq = cr; cpuWrite = cw; cpuAdrx = ca; cpuWrData = cd;
    dbgReq = dr; dbgWrite = dw; dbgLock = dl; dbgAdrx = da; dbgWrData = dd;
    memRdData = DW'($urandom);
    #1 model_check();
  endtask
  initial begin
    reset = 1; cpuReq = 0; cpuWrite = 0; cpuAdrx = '0; cpuWrData = '0;
    dbgReq = 0; dbgWrite = 0; dbgLock = 0; dbgAdrx = '0; dbgWrData = '0; memRdData = '0;
    have_next = 0; cpu_wait = 0;
    drive(1, 1, 0, 7'h05, 16'h0, 1, 0, 0, 7'h0, 16'h0);
    chk("rst_stall", cpuStall, 1);
    chk("rst_grant", cpuGrant | dbgGrant, 0);
    chk("rst_memEn", memEn, 0);
    drive(1, 0, 0, 7'h0, 16'h0, 0, 0, 0, 7'h0, 16'h0);
    drive(0, 1, 0, 7'h05, 16'h0, 0, 0, 0, 7'h0, 16'h0);
    chk("cpu_rd_grant", cpuGrant, 1);
    chk("cpu_rd_adrx", memAdrx, 7'h05);
    chk("cpu_rd_stall", cpuStall, 0);
    drive(0, 0, 0, 7'h0, 16'h0, 0, 0, 0, 7'h0, 16'h0);
    chk("cpu_rd_valid", cpuValid, 1);
    chk("cpu_rd_data", cpuRdData, memRdData);
    drive(1, 0, 0, 7'h0, 16'h0, 0, 0, 0, 7'h0, 16'h0);
    drive(0, 1, 0, 7'h11, 16'h0, 1, 0, 0, 7'h22, 16'h0);
    chk("alt0_cpu", cpuGrant, 1);
    chk("alt0_dbg", dbgGrant, 0);
    drive(0, 1, 0, 7'h11, 16'h0, 1, 0, 0, 7'h22, 16'h0);
    chk("alt1_dbg", dbgGrant, 1);
    drive(0, 1, 0, 7'h11, 16'h0, 1, 0, 0, 7'h22, 16'h0);
    chk("alt2_cpu", cpuGrant, 1);
    drive(1, 0, 0, 7'h0, 16'h0, 0, 0, 0, 7'h0, 16'h0);
    pat = 7'b1011110;
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 0, 7'h33, 16'h0, 1, 0, 1, 7'h44, 16'h0);
      chk("burst_dbg", dbgGrant, pat[i]);
      chk("burst_stall", cpuStall, pat[i]);
    end
    drive(0, 0, 0, 7'h0, 16'h0, 1, 1, 0, 7'h7F, 16'hBEEF);
    chk("dbg_wr_memWrite", memWrite, 1);
    chk("dbg_wr_adrx", memAdrx, 7'h7F);
    chk("dbg_wr_data", memWrData, 16'hBEEF);
    drive(0, 0, 0, 7'h0, 16'h0, 0, 0, 0, 7'h0, 16'h0);
    chk("dbg_wr_novalid", dbgValid, 0);
    drive(0, 1, 0, 7'h15, 16'h0, 0, 0, 0, 7'h0, 16'h0);
    chk("rst_rd_grant", cpuGrant, 1);
    #2 reset = 1;
    drive(1, 0, 0, 7'h0, 16'h0, 0, 0, 0, 7'h0, 16'h0);
    chk("rst_rd_cpuValid", cpuValid, 0);
    chk("rst_rd_dbgValid", dbgValid, 0);
    drive(0, 1, 0, 7'h1, 16'h0, 1, 0, 1, 7'h2, 16'h0);
    chk("rst_rd_noValid", cpuValid | dbgValid, 0);
    chk("rst_owner_cpu", cpuGrant, 1);
    for (int i = 0; i < 10000; i++)
      drive(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0,
            AW'($urandom), DW'($urandom));
    drive(0, 0, 0, 7'h0, 16'h0, 0, 0, 0, 7'h0, 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
